stall_ctrl: RTL and testbench
=============================

Name: stall_ctrl

Overview:
- Pipeline hazard controller that produces the 6-bit stall vector consumed by the PC, IF_ID, ID_EX, EX_MEM and MEM_WB stage registers.
- Merges the level-type load-use stall request from ID with multi-cycle operation requests from EX (divide, multiply-accumulate).
- EX requests are tracked by an internal countdown state machine, so EX only pulses a start with a cycle count.
- Sits beside the pipeline and drives every stage register's stall input.

Parameters:
- CNT_W, 6, width of the multi-cycle count input and the internal counter.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-low reset; the block is in reset while rst is 0.
- stallreq_from_id  in  1  load-use stall request, level, valid each cycle.
- ex_mc_start  in  1  one-cycle pulse: EX begins a multi-cycle op.
- ex_mc_cycles  in  CNT_W  number of stall cycles N for that op; sampled only with ex_mc_start.
- ex_mc_cancel  in  1  abort the in-flight multi-cycle op (exception/flush).
- stall  out  6  stall vector; 1 = Stop. Bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- ex_mc_busy  out  1  a multi-cycle op is counting.
- ex_mc_done  out  1  one-cycle pulse: op finished; EX result may advance this cycle.
- perf_clr  in  1  synchronous clear of the performance counters (STALL_PERF_CNT_EN only).
- perf_id_stalls  out  PERF_W  cycles stalled by ID (STALL_PERF_CNT_EN only).
- perf_ex_stalls  out  PERF_W  cycles stalled by EX (STALL_PERF_CNT_EN only).

Behaviour:
- States: IDLE, BUSY, DONE. Counter cnt holds the remaining stall cycles after the current one.
- Reset (rst=0): state=IDLE, cnt=0, perf counters=0. stall=0, ex_mc_busy=0 and ex_mc_done=0 immediately, without waiting for a clock edge, and for as long as rst=0.
- ex_req (combinational) is high in either of these cases:
  - state=IDLE and ex_mc_start=1 and ex_mc_cycles!=0 and ex_mc_cancel=0;
  - state=BUSY and ex_mc_cancel=0.
- Stall vector is combinational:
  - ex_req=1: stall=6'b001111.
  - else stallreq_from_id=1: stall=6'b000111.
  - else stall=6'b000000.
  - EX dominates: the ID request is masked while ex_req=1.
- IDLE transitions:
  - start with N=0: no stall, no state change, no done pulse.
  - start with N=1: next state DONE.
  - start with N>1: cnt<=N-1, next state BUSY.
- BUSY transitions:
  - cnt==1: next state DONE.
  - otherwise cnt<=cnt-1.
  - ex_mc_busy=1 throughout BUSY.
- DONE: stall EX bits released; ex_mc_done=1 for one cycle; next state IDLE. stallreq_from_id is honoured in DONE.
- Latency: exactly N stalled cycles, counted from and including the start cycle, then one DONE cycle.
- ex_mc_start while BUSY or DONE: ignored.
- ex_mc_cancel:
  - Highest priority in every state.
  - Drops ex_req in the same cycle.
  - Next state IDLE, cnt<=0, no done pulse.
  - Cancel coinciding with start in IDLE: the start is discarded.
- Reset asserted mid-operation: immediate return to IDLE, outputs low, no done pulse after release.
- Maximum N is 2^CNT_W-1; no wrap-around, because cnt only decrements from a nonzero value down to 1.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - perf_id_stalls increments on each cycle where stall==6'b000111.
  - perf_ex_stalls increments on each cycle where ex_req=1.
  - Both counters saturate at all-ones.
  - perf_clr zeroes both and has priority over increment.
- Undefined: the perf_clr port and the perf_* ports and logic are absent.

Decomposition:
- The shared defines header provides:
  - the Stop/NoStop encodings;
  - the stall vector width;
  - the three stall patterns (none, ID, EX);
  - the FSM state encodings.
- Natural sub-module: mc_stall_counter (FSM plus cnt, producing ex_req, ex_mc_busy, ex_mc_done).
- stall_ctrl adds the priority merge and the perf counters around it.

Test Plan:
- Reset: hold rst=0 with stallreq_from_id=1 and ex_mc_start=1 -> stall=0, busy=0, done=0; after release, outputs follow the inputs.
- Load-use: stallreq_from_id=1 for 2 cycles -> stall=6'b000111 in exactly those 2 cycles, then 0.
- Divide: ex_mc_start with ex_mc_cycles=5 -> stall=6'b001111 for 5 consecutive cycles, ex_mc_busy=1 in cycles 2-5, then one cycle with stall=0 and ex_mc_done=1. Repeat with N=1 (one stall cycle, then done) and N=0 (no stall, no done).
- Overlap: N=4 start plus stallreq_from_id=1 held high -> stall=6'b001111 for 4 cycles, then 6'b000111 in the DONE cycle with done=1.
- Cancel: N=10 start, ex_mc_cancel in cycle 3 -> stall=6'b001111 in cycles 1-2, 0 in cycle 3, busy low from cycle 4, no done pulse. Separately, assert rst=0 in cycle 3 -> same, with asynchronous clearing.
- Perf (STALL_PERF_CNT_EN): 3 ID-stall cycles plus an N=5 op -> perf_id_stalls=3, perf_ex_stalls=5; perf_clr -> both 0 next cycle.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: Stop/NoStop levels,
// stall vector width and patterns, and the multi-cycle FSM state encoding.
package stall_ctrl_pkg;

  localparam int unsigned STALL_W = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Bit order: 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
  localparam logic [STALL_W-1:0] STALL_NONE = {STALL_W{NO_STOP}};
  localparam logic [STALL_W-1:0] STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
  localparam logic [STALL_W-1:0] STALL_EX   = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/stall_ctrl_mc_stall_counter.sv
// Countdown FSM for EX multi-cycle ops: turns a start pulse plus cycle count
// into a level stall request, a busy flag and a one-cycle done pulse.
module mc_stall_counter
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_cycles,
  input  logic             i_cancel,
  output logic             o_ex_req,
  output logic             o_busy,
  output logic             o_done
);

  mc_state_e        r_state;
  mc_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // cnt holds the stall cycles still owed after the current one
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req       = 1'b0;
    if (i_cancel) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && (i_cycles != '0)) begin
            w_req = 1'b1;
            if (i_cycles == CNT_W'(1)) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_cnt_nxt   = i_cycles - CNT_W'(1);
              w_state_nxt = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          w_req = 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Reset gates the start-path request so outputs drop without a clock edge
  assign o_ex_req = w_req & i_rst_n;
  assign o_busy   = (r_state == ST_BUSY);
  assign o_done   = (r_state == ST_DONE) & ~i_cancel;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: merges ID load-use and EX multi-cycle stall
// requests into the stage stall vector. Optional perf counters: STALL_PERF_CNT_EN.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 6
`ifdef STALL_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_from_id,
  input  logic               ex_mc_start,
  input  logic [CNT_W-1:0]   ex_mc_cycles,
  input  logic               ex_mc_cancel,
  output logic [STALL_W-1:0] stall,
  output logic               ex_mc_busy,
  output logic               ex_mc_done
`ifdef STALL_PERF_CNT_EN
  ,
  input  logic               perf_clr,
  output logic [PERF_W-1:0]  perf_id_stalls,
  output logic [PERF_W-1:0]  perf_ex_stalls
`endif
);

  logic w_ex_req;

  mc_stall_counter #(
    .CNT_W (CNT_W)
  ) u_mc_cnt (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_start  (ex_mc_start),
    .i_cycles (ex_mc_cycles),
    .i_cancel (ex_mc_cancel),
    .o_ex_req (w_ex_req),
    .o_busy   (ex_mc_busy),
    .o_done   (ex_mc_done)
  );

  // EX request masks the ID request
  always_comb begin
    stall = STALL_NONE;
    if (w_ex_req) begin
      stall = STALL_EX;
    end else if (rst && stallreq_from_id) begin
      stall = STALL_ID;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_id;
  logic [PERF_W-1:0] r_perf_ex;

  // Saturating counters; clear wins over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_id <= '0;
      r_perf_ex <= '0;
    end else if (perf_clr) begin
      r_perf_id <= '0;
      r_perf_ex <= '0;
    end else begin
      if ((stall == STALL_ID) && (r_perf_id != '1)) begin
        r_perf_id <= r_perf_id + PERF_W'(1);
      end
      if (w_ex_req && (r_perf_ex != '1)) begin
        r_perf_ex <= r_perf_ex + PERF_W'(1);
      end
    end
  end

  assign perf_id_stalls = r_perf_id;
  assign perf_ex_stalls = r_perf_ex;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: per-cycle vector table plus directed
// sequences for cancel, reset mid-op, maximum count and perf counters.
module tb_stall_ctrl;

  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             stallreq_from_id = 1'b0;
  logic             ex_mc_start = 1'b0;
  logic [CNT_W-1:0] ex_mc_cycles = '0;
  logic             ex_mc_cancel = 1'b0;
  logic [5:0]       stall;
  logic             ex_mc_busy;
  logic             ex_mc_done;
`ifdef STALL_PERF_CNT_EN
  logic             perf_clr = 1'b0;
  logic [31:0]      perf_id_stalls;
  logic [31:0]      perf_ex_stalls;
`endif

  always #5 clk = ~clk;

  stall_ctrl #(
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (stallreq_from_id),
    .ex_mc_start      (ex_mc_start),
    .ex_mc_cycles     (ex_mc_cycles),
    .ex_mc_cancel     (ex_mc_cancel),
    .stall            (stall),
    .ex_mc_busy       (ex_mc_busy),
    .ex_mc_done       (ex_mc_done)
`ifdef STALL_PERF_CNT_EN
    ,
    .perf_clr         (perf_clr),
    .perf_id_stalls   (perf_id_stalls),
    .perf_ex_stalls   (perf_ex_stalls)
`endif
  );

  typedef struct {
    logic       rst_n;
    logic       id;
    logic       start;
    logic [5:0] cyc;
    logic       cancel;
    logic [5:0] e_stall;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  localparam logic [5:0] S0  = 6'b000000;
  localparam logic [5:0] SID = 6'b000111;
  localparam logic [5:0] SEX = 6'b001111;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic id, input logic st, input logic [5:0] cy,
                       input logic cn);
    @(negedge clk);
    rst = r; stallreq_from_id = id; ex_mc_start = st; ex_mc_cycles = cy; ex_mc_cancel = cn;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] es, input logic eb, input logic ed);
    chk({tag, ".stall"}, 32'(stall), 32'(es));
    chk({tag, ".busy"}, 32'(ex_mc_busy), 32'(eb));
    chk({tag, ".done"}, 32'(ex_mc_done), 32'(ed));
  endtask

  task automatic add(input logic r, input logic id, input logic st, input logic [5:0] cy,
                     input logic cn, input logic [5:0] es, input logic eb, input logic ed);
    vec_t v;
    v = '{r, id, st, cy, cn, es, eb, ed};
    tbl.push_back(v);
  endtask

  initial begin
    int cnt_stall;
    bit seen_done;

    // Reset held with active requests, then release
    add(0, 1, 1, 6'd5, 0, S0, 0, 0);
    add(0, 1, 1, 6'd5, 0, S0, 0, 0);
    add(1, 0, 0, 6'd0, 0, S0, 0, 0);
    // Load-use for two cycles
    add(1, 1, 0, 6'd0, 0, SID, 0, 0);
    add(1, 1, 0, 6'd0, 0, SID, 0, 0);
    add(1, 0, 0, 6'd0, 0, S0, 0, 0);
    // Divide N=5
    add(1, 0, 1, 6'd5, 0, SEX, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 6'd0, 0, SEX, 1, 0);
    add(1, 0, 0, 6'd0, 0, S0, 0, 1);
    add(1, 0, 0, 6'd0, 0, S0, 0, 0);
    // N=1
    add(1, 0, 1, 6'd1, 0, SEX, 0, 0);
    add(1, 0, 0, 6'd0, 0, S0, 0, 1);
    add(1, 0, 0, 6'd0, 0, S0, 0, 0);
    // N=0: nothing happens
    add(1, 0, 1, 6'd0, 0, S0, 0, 0);
    add(1, 0, 0, 6'd0, 0, S0, 0, 0);
    // Overlap N=4 with ID request held
    add(1, 1, 1, 6'd4, 0, SEX, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 6'd0, 0, SEX, 1, 0);
    add(1, 1, 0, 6'd0, 0, SID, 0, 1);
    add(1, 0, 0, 6'd0, 0, S0, 0, 0);
    // N=3 with a second start while busy (ignored)
    add(1, 0, 1, 6'd3, 0, SEX, 0, 0);
    add(1, 0, 1, 6'd7, 0, SEX, 1, 0);
    add(1, 0, 0, 6'd0, 0, SEX, 1, 0);
    add(1, 0, 0, 6'd0, 0, S0, 0, 1);
    add(1, 0, 0, 6'd0, 0, S0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].id, tbl[i].start, tbl[i].cyc, tbl[i].cancel);
      chk_out($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_busy, tbl[i].e_done);
    end

    // Cancel N=10 in cycle 3
    drive(1, 0, 1, 6'd10, 0); chk_out("cxl.c1", SEX, 0, 0);
    drive(1, 0, 0, 6'd0, 0);  chk_out("cxl.c2", SEX, 1, 0);
    drive(1, 0, 0, 6'd0, 1);  chk_out("cxl.c3", S0, 1, 0);
    drive(1, 0, 0, 6'd0, 0);  chk_out("cxl.c4", S0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 6'd0, 0); chk_out($sformatf("cxl.post%0d", i), S0, 0, 0);
    end

    // Cancel together with start in IDLE discards the start
    drive(1, 0, 1, 6'd5, 1); chk_out("cxs.c1", S0, 0, 0);
    drive(1, 0, 0, 6'd0, 0); chk_out("cxs.c2", S0, 0, 0);

    // Reset mid-operation clears outputs asynchronously
    drive(1, 0, 1, 6'd10, 0); chk_out("rmid.c1", SEX, 0, 0);
    drive(1, 0, 0, 6'd0, 0);  chk_out("rmid.c2", SEX, 1, 0);
    drive(1, 0, 0, 6'd0, 0);  chk_out("rmid.c3pre", SEX, 1, 0);
    #1 rst = 1'b0;
    #1 chk_out("rmid.c3async", S0, 0, 0);
    drive(1, 0, 0, 6'd0, 0);  chk_out("rmid.c4", S0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 6'd0, 0);
      chk($sformatf("rmid.nodone%0d", i), 32'(ex_mc_done), 32'd0);
    end

    // Maximum count N=63
    cnt_stall = 0;
    seen_done = 1'b0;
    drive(1, 0, 1, 6'd63, 0);
    if (stall == SEX) cnt_stall++;
    for (int i = 0; i < 100 && !seen_done; i++) begin
      drive(1, 0, 0, 6'd0, 0);
      if (ex_mc_done) seen_done = 1'b1;
      else if (stall == SEX) cnt_stall++;
    end
    chk("max.done_seen", 32'(seen_done), 32'd1);
    chk("max.stall_cycles", 32'(cnt_stall), 32'd63);
    drive(1, 0, 0, 6'd0, 0); chk_out("max.idle", S0, 0, 0);

`ifdef STALL_PERF_CNT_EN
    @(negedge clk); perf_clr = 1'b1;
    @(negedge clk); perf_clr = 1'b0;
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 6'd0, 0);
    drive(1, 0, 1, 6'd5, 0);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 6'd0, 0);
    chk("perf.id", perf_id_stalls, 32'd3);
    chk("perf.ex", perf_ex_stalls, 32'd5);
    @(negedge clk); perf_clr = 1'b1;
    @(negedge clk); perf_clr = 1'b0;
    #1;
    chk("perf.id_clr", perf_id_stalls, 32'd0);
    chk("perf.ex_clr", perf_ex_stalls, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
